pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side program-counter sequencer for the simple CPU; it is the consumer of the EX-stage branch comparator's `branch_taken` result. It holds the PC, advances it by 4 per fetch, and redirects to the EX-stage target on a taken branch or jump. On a redirect it raises a multi-cycle flush that kills wrong-path instructions in IF/ID. A misaligned redirect target halts fetch and raises a trap pulse.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, number of cycles `flush` is held after a redirect; legal range 1–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  1  hold the PC in RUN; from hazard unit.
- `ex_valid`  in  1  a valid control-flow instruction is in EX.
- `ex_is_branch`  in  1  the EX instruction is a conditional branch.
- `ex_is_jump`  in  1  the EX instruction is JAL/JALR (unconditional).
- `branch_taken`  in  1  branch-comparator result for the EX branch.
- `ex_target`  in  32  redirect target address.
- `pc`  out  32  current fetch address.
- `pc_valid`  out  1  fetch request valid this cycle.
- `flush`  out  1  kill IF/ID contents.
- `misalign`  out  1  one-cycle pulse on a misaligned redirect target.
- `misalign_addr`  out  32  captured misaligned target.
- `branch_count`, `taken_count`  out  32 each  statistics; present only when `PC_SEQ_STATS_EN` is defined.

## Operation
- States: RUN, FLUSH, HALT. Reset values: state=RUN, `pc`=RESET_PC, flush counter=0, `misalign_addr`=0, stats=0.
- Output reset values: `pc_valid`=0, `flush`=0, `misalign`=0.
- Redirect condition `redir` = `ex_valid & (ex_is_jump | (ex_is_branch & branch_taken))`. If `ex_is_jump` and `ex_is_branch` are both high, the instruction is treated as a jump.
- `pc_valid` is 1 in RUN when not in reset. It is 0 in FLUSH, in HALT, and during reset.

RUN:
- If `redir` and `ex_target[1:0]==0`:
  - `pc` <= `ex_target`, `flush` <= 1, counter <= FLUSH_CYCLES-1, go to FLUSH.
  - `redir` has priority over `stall`.
- If `redir` and `ex_target[1:0]!=0`:
  - `pc` is unchanged, `misalign` <= 1 for exactly one cycle, `misalign_addr` <= `ex_target`, `flush` <= 1, go to HALT.
- Otherwise, if `stall` is high, `pc` holds.
- Otherwise `pc` <= `pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).

FLUSH:
- `pc` holds; `flush` is 1; `stall` and all `ex_*` inputs are ignored.
- The counter decrements each cycle. When the counter is 0, `flush` <= 0 and the block goes to RUN.

HALT:
- `flush` stays 1, `pc_valid` stays 0; all inputs except `rst` are ignored. Only `rst` exits HALT.

Reset:
- Reset mid-FLUSH or in HALT returns the block to reset values on the next edge.

## Timing
- Redirect sampled at edge N: `pc`=target and `flush`=1 from cycle N+1.
- `flush` is high for exactly FLUSH_CYCLES cycles: N+1 .. N+FLUSH_CYCLES.
- The first valid fetch of the target is at cycle N+FLUSH_CYCLES+1, followed by target+4 at the next cycle.
- Misalign sampled at edge N: `misalign`=1 in cycle N+1 only; `flush`=1 from cycle N+1 onward.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PC_SEQ_STATS_EN` defined:
  - `branch_count` increments on every RUN-state cycle with `ex_valid & ex_is_branch & ~ex_is_jump`.
  - `taken_count` increments when that branch is also taken.
  - Both counters wrap at 2^32 and are cleared by `rst`.
- `PC_SEQ_STATS_EN` not defined: both ports and all counter logic are absent.
- Core behaviour is identical with or without the macro.

## Structure
- Shared package `cpu_pkg` holds:
  - the `pc_seq_state_t` enum (RUN/FLUSH/HALT);
  - XLEN=32 and the default RESET_PC;
  - the branch funct3 constants used by the comparator: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
- One sub-module, `branch_stats`, holds the two statistics counters. It is instantiated only under `PC_SEQ_STATS_EN`.

## Test plan
All scenarios use RESET_PC=0 and FLUSH_CYCLES=2.
- **Reset and sequential fetch:** hold `rst` for 2 cycles -> `pc`=0, `pc_valid`=0, `flush`=0. After release -> `pc` reads 0, 4, 8 on consecutive cycles with `pc_valid`=1.
- **Taken branch:** at `pc`=8, drive `ex_valid`=1, `ex_is_branch`=1, `branch_taken`=1, `ex_target`=0x100 -> next 2 cycles `pc`=0x100, `flush`=1, `pc_valid`=0. Then `pc`=0x100 then 0x104 with `pc_valid`=1. With stats enabled: `branch_count`=1, `taken_count`=1.
- **Not-taken branch plus stall priority:** drive `branch_taken`=0 -> `pc` advances by 4, `flush` stays 0, `taken_count` is unchanged. Then drive `stall`=1 together with a jump to 0x200 -> redirect occurs and `pc`=0x200 on the next cycle.
- **Misaligned jump:** drive `ex_is_jump`=1, `ex_target`=0x102 -> `misalign`=1 for one cycle, `misalign_addr`=0x102, `pc` unchanged. `pc_valid`=0 and `flush`=1 hold for 10+ cycles until `rst`.
- **Wrap and reset mid-flush:** let `pc` reach 0xFFFF_FFFC -> the next `pc` is 0. Redirect to 0x40, then assert `rst` in the first flush cycle -> next cycle `pc`=0, `flush`=0, `pc_valid`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch-side PC sequencer and the EX-stage
// branch comparator.
//   - pc_seq_state_t : PC sequencer FSM states
//   - XLEN, RESET_PC_DEFAULT : datapath width and default reset fetch address
//   - F3_* : branch funct3 encodings decoded by the comparator
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        PCS_RUN   = 2'd0,
        PCS_FLUSH = 2'd1,
        PCS_HALT  = 2'd2
    } pc_seq_state_t;

endpackage

// File: rtl/branch_stats.sv
// branch_stats: conditional-branch statistics counters for the PC sequencer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears both counts)
//   count_en       : sequencer is in a state where EX is being consumed
//   branch_seen    : a valid conditional branch (not a jump) is in EX
//   branch_taken   : comparator result for that branch
//   branch_count   : number of branches seen (wraps at 2^32)
//   taken_count    : number of those that were taken (wraps at 2^32)
module branch_stats
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            count_en,
    input  logic            branch_seen,
    input  logic            branch_taken,
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] taken_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (count_en && branch_seen) begin
            branch_count <= branch_count + 32'd1;
            if (branch_taken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side program counter. Advances the PC by 4 per issued
// fetch, redirects to the EX target on a taken branch or jump, holds flush for
// FLUSH_CYCLES cycles after a redirect, and halts with a trap pulse on a
// misaligned redirect target.
// Optional feature macro: PC_SEQ_STATS_EN adds branch_count / taken_count.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : hold the PC while running
//   ex_valid, ex_is_branch,
//   ex_is_jump, branch_taken : EX-stage control-flow information
//   ex_target                : redirect target
//   pc, pc_valid             : fetch address and request valid
//   flush                    : kill IF/ID contents
//   misalign, misalign_addr  : trap pulse and captured bad target
//   branch_count, taken_count: statistics (PC_SEQ_STATS_EN only)
//
// state     | meaning
// ----------+-----------------------------------------------------
// PCS_RUN   | fetching; PC advances by 4 unless stalled
// PCS_FLUSH | redirect taken; PC parked on target, flush held high
// PCS_HALT  | misaligned target seen; fetch stopped until reset
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign,
`ifdef PC_SEQ_STATS_EN
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] taken_count,
`endif
    output logic [XLEN-1:0] misalign_addr
);

    pc_seq_state_t   state_q, state_d;
    logic [XLEN-1:0] pc_d, maddr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pc_valid_d, flush_d, misalign_d;
    logic            redir;

    assign redir = ex_valid & (ex_is_jump | (ex_is_branch & branch_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PCS_RUN;
            pc            <= RESET_PC;
            cnt_q         <= '0;
            misalign_addr <= '0;
            pc_valid      <= 1'b0;
            flush         <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc            <= pc_d;
            cnt_q         <= cnt_d;
            misalign_addr <= maddr_d;
            pc_valid      <= pc_valid_d;
            flush         <= flush_d;
            misalign      <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        cnt_d      = cnt_q;
        maddr_d    = misalign_addr;
        pc_valid_d = 1'b0;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            PCS_RUN: begin
                if (redir && (ex_target[1:0] == 2'b00)) begin
                    pc_d    = ex_target;
                    flush_d = 1'b1;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                    state_d = PCS_FLUSH;
                end else if (redir) begin
                    maddr_d    = ex_target;
                    misalign_d = 1'b1;
                    flush_d    = 1'b1;
                    state_d    = PCS_HALT;
                end else begin
                    pc_valid_d = 1'b1;
                    // The PC only moves past an address that has actually been
                    // presented as valid, so the first cycle out of reset or
                    // flush fetches the parked address itself.
                    if (!stall && pc_valid) begin
                        pc_d = pc + 32'd4;
                    end
                end
            end
            PCS_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    pc_valid_d = 1'b1;
                    state_d    = PCS_RUN;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            PCS_HALT: begin
                flush_d = 1'b1;
            end
            default: begin
                state_d = PCS_RUN;
            end
        endcase
    end

`ifdef PC_SEQ_STATS_EN
    branch_stats u_branch_stats (
        .clk          (clk),
        .rst          (rst),
        .count_en     (state_q == PCS_RUN),
        .branch_seen  (ex_valid & ex_is_branch & ~ex_is_jump),
        .branch_taken (branch_taken),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );
`endif

endmodule
